// File: rtl/c3lib_ckmux4_sel_ctl.sv
// Select sequencer for a 4:1 clock mux: gates the clock off, switches
// s1/s0, waits out a settle window, then re-enables the clock.
module c3lib_ckmux4_sel_ctl #(
    parameter int         GATE_OFF_CYC = 4,
    parameter int         SETTLE_CYC   = 8,
    parameter int         CNT_W        = 4,
    parameter logic [1:0] RST_SEL      = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel_req,
    input  logic       sel_req_vld,
    output logic       sel_req_rdy,
    output logic       s0,
    output logic       s1,
    output logic       ck_gate_en,
    output logic       sel_done,
    output logic [1:0] cur_sel
);

    typedef enum logic [1:0] {
        SETTLE   = 2'd0,
        IDLE     = 2'd1,
        GATE_OFF = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       sel_q, sel_d;
    logic             gate_q, gate_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        gate_d  = gate_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_req_vld) begin
                    if (sel_req == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = sel_req;
                        gate_d  = 1'b0;
                        cnt_d   = GATE_LD;
                        state_d = GATE_OFF;
                    end
                end
            end
            // select moves only here, with the gate already closed
            GATE_OFF: begin
                if (cnt_q == '0) begin
                    sel_d   = pend_q;
                    cnt_d   = SETTLE_LD;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    gate_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = SETTLE_LD;
                gate_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SETTLE;
            cnt_q   <= SETTLE_LD;
            pend_q  <= RST_SEL;
            sel_q   <= RST_SEL;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
        end
    end

    assign sel_req_rdy = (state_q == IDLE);
    assign s0          = sel_q[0];
    assign s1          = sel_q[1];
    assign cur_sel     = sel_q;
    assign ck_gate_en  = gate_q;
    assign sel_done    = done_q;

endmodule

// File: tb/tb_c3lib_ckmux4_sel_ctl.sv
// Bench for c3lib_ckmux4_sel_ctl: default instance plus a 1/1-cycle
// instance, checked against an edge-scheduled model and literal points.
module tb_c3lib_ckmux4_sel_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0, vld0, rdy0, s0_0, s1_0, gate0, done0;
    logic [1:0] req0, cur0;
    logic       rst_n1, vld1, rdy1, s0_1, s1_1, gate1, done1;
    logic [1:0] req1, cur1;

    c3lib_ckmux4_sel_ctl u_dut0 (
        .clk(clk), .rst_n(rst_n0), .sel_req(req0), .sel_req_vld(vld0),
        .sel_req_rdy(rdy0), .s0(s0_0), .s1(s1_0), .ck_gate_en(gate0),
        .sel_done(done0), .cur_sel(cur0)
    );

    c3lib_ckmux4_sel_ctl #(
        .GATE_OFF_CYC(1), .SETTLE_CYC(1), .CNT_W(4), .RST_SEL(2'b00)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .sel_req(req1), .sel_req_vld(vld1),
        .sel_req_rdy(rdy1), .s0(s0_1), .s1(s1_1), .ck_gate_en(gate1),
        .sel_done(done1), .cur_sel(cur1)
    );

    int nvec = 0;
    int nerr = 0;
    int ncyc = 0;

    task automatic chk(string nm, logic [1:0] got, logic [1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)",
                     nm, got, exp, ncyc);
        end
    endtask

    // Model: each transaction is a schedule of absolute edge numbers.
    int         end_e[2];
    int         sw_e[2];
    logic [1:0] tgt[2];
    logic [1:0] esel[2];
    bit         egate[2], edone[2], busy[2], live[2];

    task automatic mstep(int k, logic rst, logic vld, logic [1:0] req);
        int g = (k == 0) ? 4 : 1;
        int s = (k == 0) ? 8 : 1;
        if (!rst) begin
            live[k]  = 1'b1;
            esel[k]  = 2'b00;
            egate[k] = 1'b0;
            edone[k] = 1'b0;
            busy[k]  = 1'b1;
            sw_e[k]  = -1;
            end_e[k] = ncyc + s;
        end else if (live[k]) begin
            edone[k] = 1'b0;
            if (busy[k]) begin
                if (ncyc == sw_e[k]) esel[k] = tgt[k];
                if (ncyc == end_e[k]) begin
                    egate[k] = 1'b1;
                    edone[k] = 1'b1;
                    busy[k]  = 1'b0;
                end
            end else if (vld) begin
                if (req == esel[k]) begin
                    edone[k] = 1'b1;
                end else begin
                    tgt[k]   = req;
                    egate[k] = 1'b0;
                    sw_e[k]  = ncyc + g;
                    end_e[k] = ncyc + g + s;
                    busy[k]  = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        ncyc++;
        mstep(0, rst_n0, vld0, req0);
        mstep(1, rst_n1, vld1, req1);
    end

    logic [1:0] psel[2];
    logic       pgate[2];
    bit         pvalid[2];
    bit         b2b_on = 1'b0;
    int         run1 = 0;
    int         runs[$];

    task automatic cmp(int k, logic [1:0] cur, logic sb0, logic sb1,
                       logic gate, logic done, logic rdy);
        chk($sformatf("m%0d_cur_sel", k), cur, esel[k]);
        chk($sformatf("m%0d_s0", k), sb0, esel[k][0]);
        chk($sformatf("m%0d_s1", k), sb1, esel[k][1]);
        chk($sformatf("m%0d_gate", k), gate, egate[k]);
        chk($sformatf("m%0d_done", k), done, edone[k]);
        chk($sformatf("m%0d_rdy", k), rdy, !busy[k]);
        if (pvalid[k] && cur !== psel[k])
            chk($sformatf("m%0d_sel_chg_gated", k),
                {pgate[k], gate}, 2'b00);
        psel[k]   = cur;
        pgate[k]  = gate;
        pvalid[k] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (live[0]) cmp(0, cur0, s0_0, s1_0, gate0, done0, rdy0);
        if (live[1]) cmp(1, cur1, s0_1, s1_1, gate1, done1, rdy1);
        if (b2b_on) begin
            if (gate1 === 1'b0) begin
                run1++;
            end else if (run1 > 0) begin
                runs.push_back(run1);
                run1 = 0;
            end
        end
    end

    task automatic neg(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic seq0();
        rst_n0 = 1'b0; vld0 = 1'b0; req0 = 2'd0;
        repeat (3) begin
            neg(1);
            chk("rst_sel", cur0, 2'd0);
            chk("rst_gate", gate0, 1'b0);
        end
        rst_n0 = 1'b1;
        neg(7);
        chk("rel_gate_early", gate0, 1'b0);
        chk("rel_rdy_early", rdy0, 1'b0);
        neg(1);
        chk("rel_gate", gate0, 1'b1);
        chk("rel_done", done0, 1'b1);
        chk("rel_rdy", rdy0, 1'b1);
        neg(1);
        chk("rel_done_pulse", done0, 1'b0);
        // switch 0 -> 2
        req0 = 2'd2; vld0 = 1'b1;
        neg(1); vld0 = 1'b0;
        chk("sw2_gate_off", gate0, 1'b0);
        neg(3);
        chk("sw2_sel_hold", cur0, 2'd0);
        neg(1);
        chk("sw2_sel_new", cur0, 2'd2);
        neg(7);
        chk("sw2_gate_still", gate0, 1'b0);
        neg(1);
        chk("sw2_gate_on", gate0, 1'b1);
        chk("sw2_done", done0, 1'b1);
        // switch 2 -> 3, then same-select 3
        req0 = 2'd3; vld0 = 1'b1;
        neg(1); vld0 = 1'b0;
        neg(12);
        chk("sw3_done", done0, 1'b1);
        chk("sw3_sel", cur0, 2'd3);
        req0 = 2'd3; vld0 = 1'b1;
        neg(1); vld0 = 1'b0;
        chk("same_done", done0, 1'b1);
        chk("same_gate", gate0, 1'b1);
        chk("same_sel", cur0, 2'd3);
        neg(1);
        chk("same_done_pulse", done0, 1'b0);
        // switch 3 -> 2 with junk requests while busy
        req0 = 2'd2; vld0 = 1'b1;
        neg(1);
        repeat (10) begin
            vld0 = 1'($urandom_range(0, 1));
            req0 = 2'($urandom_range(0, 3));
            neg(1);
        end
        vld0 = 1'b0;
        neg(2);
        chk("junk_done", done0, 1'b1);
        chk("junk_sel", cur0, 2'd2);
        // reset during GATE_OFF with pend_sel = 1
        req0 = 2'd1; vld0 = 1'b1;
        neg(1); vld0 = 1'b0;
        neg(1);
        rst_n0 = 1'b0;
        neg(1);
        chk("abort_sel", cur0, 2'd0);
        chk("abort_gate", gate0, 1'b0);
        chk("abort_rdy", rdy0, 1'b0);
        rst_n0 = 1'b1;
        neg(8);
        chk("abort_gate_on", gate0, 1'b1);
        chk("abort_done", done0, 1'b1);
        chk("abort_sel_kept", cur0, 2'd0);
        neg(2);
    endtask

    task automatic wait_done1(output int n);
        n = 0;
        do begin
            neg(1);
            n++;
        end while (done1 !== 1'b1 && n < 20);
        chk("b2b_done_seen", done1, 1'b1);
    endtask

    task automatic seq1();
        int n;
        rst_n1 = 1'b0; vld1 = 1'b0; req1 = 2'd0;
        neg(3);
        rst_n1 = 1'b1;
        neg(1);
        chk("b2b_rel_gate", gate1, 1'b1);
        chk("b2b_rel_done", done1, 1'b1);
        neg(1);
        b2b_on = 1'b1;
        req1 = 2'd1; vld1 = 1'b1;
        wait_done1(n);
        chk("b2b_first_lat", 2'(n), 2'd3);
        chk("b2b_first_sel", cur1, 2'd1);
        req1 = 2'd3;
        wait_done1(n);
        chk("b2b_gap", 2'(n), 2'd3);
        chk("b2b_second_sel", cur1, 2'd3);
        vld1 = 1'b0;
        neg(3);
        chk("b2b_runs", 2'(runs.size()), 2'd2);
        foreach (runs[i]) chk("b2b_run_len", 2'(runs[i]), 2'd2);
    endtask

    initial begin
        fork
            seq0();
            seq1();
        join
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
